// File: rtl/ompss_cmd_pkg.sv
// Command-protocol constants and endpoint FSM state shared by the
// accelerator command endpoint and its argument buffer.
package ompss_cmd_pkg;

  localparam logic [7:0] CMD_EXEC_TASK = 8'h01;
  localparam logic [7:0] CMD_FINISHED  = 8'h03;

  localparam int unsigned HDR_FIELD_W   = 8;
  localparam int unsigned HDR_CODE_LSB  = 0;
  localparam int unsigned HDR_NARGS_LSB = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TID,
    ST_PID,
    ST_ARGS,
    ST_START,
    ST_RUN,
    ST_FIN0,
    ST_FIN1,
    ST_DRAIN
  } cmd_state_t;

endpackage

// File: rtl/ompss_arg_regfile.sv
// Task argument buffer: one synchronous write port, one asynchronous read port.
// Out-of-range addresses are ignored on write and read back as zero.
module ompss_arg_regfile #(
  parameter int unsigned DEPTH = 15
) (
  input  logic        clk,
  input  logic        i_wr_en,
  input  logic [7:0]  i_wr_addr,
  input  logic [63:0] i_wr_data,
  input  logic [7:0]  i_rd_addr,
  output logic [63:0] o_rd_data
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]  DEPTH8 = 8'(DEPTH);

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_wr_idx = i_wr_addr[AW-1:0];
  assign w_rd_idx = i_rd_addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (i_wr_en && (i_wr_addr < DEPTH8)) begin
      r_mem[w_wr_idx] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (i_rd_addr < DEPTH8) begin
      o_rd_data = r_mem[w_rd_idx];
    end
  end

endmodule

// File: rtl/ompss_acc_cmd_endpoint.sv
// Accelerator-side command endpoint: parses execute-task commands, hands the
// task to the kernel via start/done, and returns a two-beat finish notice.
module ompss_acc_cmd_endpoint
  import ompss_cmd_pkg::*;
#(
  parameter int unsigned ACC_ID   = 0,
  parameter int unsigned MAX_ACCS = 16,
  parameter int unsigned MAX_ARGS = 15
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cmdin_in_tvalid,
  output logic                        cmdin_in_tready,
  input  logic [63:0]                 cmdin_in_tdata,
  input  logic                        cmdin_in_tlast,
  output logic                        cmdout_out_tvalid,
  input  logic                        cmdout_out_tready,
  output logic [$clog2(MAX_ACCS)-1:0] cmdout_out_tid,
  output logic [63:0]                 cmdout_out_tdata,
  output logic                        task_start_valid,
  input  logic                        task_start_ready,
  output logic [63:0]                 task_id,
  output logic [63:0]                 parent_id,
  output logic [7:0]                  task_nargs,
  input  logic [7:0]                  arg_idx,
  output logic [63:0]                 arg_data,
  input  logic                        task_done_valid,
  output logic                        task_done_ready,
  output logic [1:0]                  err_sticky
);

  localparam int unsigned TID_W     = $clog2(MAX_ACCS);
  localparam logic [7:0]  MAX_ARGS8 = 8'(MAX_ARGS);

  cmd_state_t  r_state;
  cmd_state_t  w_next;
  logic [63:0] r_task_id;
  logic [63:0] r_parent_id;
  logic [7:0]  r_hdr_nargs;
  logic [7:0]  r_wr_ptr;
  logic [7:0]  r_task_nargs;
  logic [1:0]  r_err;

  logic                   w_beat;
  logic [HDR_FIELD_W-1:0] w_code;
  logic [HDR_FIELD_W-1:0] w_nargs_in;
  logic                   w_arg_room;
  logic                   w_wr_en;
  logic [7:0]             w_rcv_cnt;
  logic [7:0]             w_final_nargs;
  logic [63:0]            w_rd_data;

  assign w_beat     = cmdin_in_tvalid && cmdin_in_tready;
  assign w_code     = cmdin_in_tdata[HDR_CODE_LSB +: HDR_FIELD_W];
  assign w_nargs_in = cmdin_in_tdata[HDR_NARGS_LSB +: HDR_FIELD_W];
  assign w_arg_room = (r_wr_ptr < MAX_ARGS8);
  assign w_wr_en    = (r_state == ST_ARGS) && w_beat && w_arg_room;
  // Received count never exceeds MAX_ARGS, so min() with the header count
  // yields min(nargs, MAX_ARGS) or the short count on an early tlast.
  assign w_rcv_cnt     = r_wr_ptr + {7'd0, w_wr_en};
  assign w_final_nargs = (w_rcv_cnt < r_hdr_nargs) ? w_rcv_cnt : r_hdr_nargs;

  always_comb begin
    w_next            = r_state;
    cmdin_in_tready   = 1'b0;
    task_start_valid  = 1'b0;
    task_done_ready   = 1'b0;
    cmdout_out_tvalid = 1'b0;
    cmdout_out_tdata  = '0;
    case (r_state)
      ST_IDLE: begin
        cmdin_in_tready = 1'b1;
        if (cmdin_in_tvalid) begin
          if (w_code == CMD_EXEC_TASK) w_next = ST_TID;
          else if (!cmdin_in_tlast)    w_next = ST_DRAIN;
        end
      end
      ST_TID: begin
        cmdin_in_tready = 1'b1;
        if (cmdin_in_tvalid) w_next = cmdin_in_tlast ? ST_START : ST_PID;
      end
      ST_PID: begin
        cmdin_in_tready = 1'b1;
        if (cmdin_in_tvalid) begin
          w_next = (cmdin_in_tlast || (r_hdr_nargs == 8'd0)) ? ST_START : ST_ARGS;
        end
      end
      ST_ARGS: begin
        cmdin_in_tready = 1'b1;
        if (cmdin_in_tvalid && cmdin_in_tlast) w_next = ST_START;
      end
      ST_START: begin
        task_start_valid = 1'b1;
        if (task_start_ready) w_next = ST_RUN;
      end
      ST_RUN: begin
        task_done_ready = 1'b1;
        if (task_done_valid) w_next = ST_FIN0;
      end
      ST_FIN0: begin
        cmdout_out_tvalid = 1'b1;
        cmdout_out_tdata  = {56'h0, CMD_FINISHED};
        if (cmdout_out_tready) w_next = ST_FIN1;
      end
      ST_FIN1: begin
        cmdout_out_tvalid = 1'b1;
        cmdout_out_tdata  = r_task_id;
        if (cmdout_out_tready) w_next = ST_IDLE;
      end
      ST_DRAIN: begin
        cmdin_in_tready = 1'b1;
        if (cmdin_in_tvalid && cmdin_in_tlast) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_task_id    <= '0;
      r_parent_id  <= '0;
      r_hdr_nargs  <= '0;
      r_wr_ptr     <= '0;
      r_task_nargs <= '0;
      r_err        <= '0;
    end else begin
      r_state <= w_next;
      if (w_beat) begin
        case (r_state)
          ST_IDLE: begin
            if (w_code == CMD_EXEC_TASK) begin
              r_hdr_nargs  <= w_nargs_in;
              r_wr_ptr     <= '0;
              r_task_nargs <= '0;
            end else begin
              r_err[0] <= 1'b1;
            end
          end
          ST_TID: r_task_id   <= cmdin_in_tdata;
          ST_PID: r_parent_id <= cmdin_in_tdata;
          ST_ARGS: begin
            if (w_arg_room) r_wr_ptr <= r_wr_ptr + 8'd1;
            else            r_err[1] <= 1'b1;
            if (cmdin_in_tlast) r_task_nargs <= w_final_nargs;
          end
          default: ;
        endcase
      end
    end
  end

  ompss_arg_regfile #(
    .DEPTH (MAX_ARGS)
  ) u_args (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (cmdin_in_tdata),
    .i_rd_addr (arg_idx),
    .o_rd_data (w_rd_data)
  );

  assign arg_data       = (arg_idx < r_task_nargs) ? w_rd_data : '0;
  assign cmdout_out_tid = TID_W'(ACC_ID);
  assign task_id        = r_task_id;
  assign parent_id      = r_parent_id;
  assign task_nargs     = r_task_nargs;
  assign err_sticky     = r_err;

endmodule

// File: tb/tb_ompss_acc_cmd_endpoint.sv
// Directed bench for the accelerator command endpoint with hand-computed
// expectations: parsing, argument overflow, bad codes, backpressure, reset.
module tb_ompss_acc_cmd_endpoint;

  localparam int unsigned ACC_ID   = 3;
  localparam int unsigned MAX_ACCS = 16;
  localparam int unsigned MAX_ARGS = 15;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmdin_in_tvalid;
  logic        cmdin_in_tready;
  logic [63:0] cmdin_in_tdata;
  logic        cmdin_in_tlast;
  logic        cmdout_out_tvalid;
  logic        cmdout_out_tready;
  logic [3:0]  cmdout_out_tid;
  logic [63:0] cmdout_out_tdata;
  logic        task_start_valid;
  logic        task_start_ready;
  logic [63:0] task_id;
  logic [63:0] parent_id;
  logic [7:0]  task_nargs;
  logic [7:0]  arg_idx;
  logic [63:0] arg_data;
  logic        task_done_valid;
  logic        task_done_ready;
  logic [1:0]  err_sticky;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  ompss_acc_cmd_endpoint #(
    .ACC_ID   (ACC_ID),
    .MAX_ACCS (MAX_ACCS),
    .MAX_ARGS (MAX_ARGS)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .cmdin_in_tvalid   (cmdin_in_tvalid),
    .cmdin_in_tready   (cmdin_in_tready),
    .cmdin_in_tdata    (cmdin_in_tdata),
    .cmdin_in_tlast    (cmdin_in_tlast),
    .cmdout_out_tvalid (cmdout_out_tvalid),
    .cmdout_out_tready (cmdout_out_tready),
    .cmdout_out_tid    (cmdout_out_tid),
    .cmdout_out_tdata  (cmdout_out_tdata),
    .task_start_valid  (task_start_valid),
    .task_start_ready  (task_start_ready),
    .task_id           (task_id),
    .parent_id         (parent_id),
    .task_nargs        (task_nargs),
    .arg_idx           (arg_idx),
    .arg_data          (arg_data),
    .task_done_valid   (task_done_valid),
    .task_done_ready   (task_done_ready),
    .err_sticky        (err_sticky)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and wait (bounded) for it to be accepted.
  task automatic send(input logic [63:0] d, input logic l);
    int unsigned n = 0;
    cmdin_in_tvalid = 1'b1;
    cmdin_in_tdata  = d;
    cmdin_in_tlast  = l;
    while (!cmdin_in_tready && n < 20) begin
      tick();
      n++;
    end
    if (!cmdin_in_tready) check_eq("send_tready", 64'(cmdin_in_tready), 64'd1);
    tick();
    cmdin_in_tvalid = 1'b0;
    cmdin_in_tlast  = 1'b0;
  endtask

  task automatic check_arg(input string tag, input logic [7:0] idx, input logic [63:0] exp);
    arg_idx = idx;
    #1;
    check_eq(tag, arg_data, exp);
  endtask

  // Start handshake, done, then both finish beats with tready held high.
  task automatic finish(input logic [63:0] tid);
    task_start_ready = 1'b1;
    tick();
    task_start_ready = 1'b0;
    check_eq("run_done_ready", 64'(task_done_ready), 64'd1);
    check_eq("run_start_low", 64'(task_start_valid), 64'd0);
    cmdout_out_tready = 1'b1;
    task_done_valid   = 1'b1;
    tick();
    task_done_valid = 1'b0;
    check_eq("fin0_valid", 64'(cmdout_out_tvalid), 64'd1);
    check_eq("fin0_data", cmdout_out_tdata, 64'h3);
    check_eq("fin0_tid", 64'(cmdout_out_tid), 64'(ACC_ID));
    tick();
    check_eq("fin1_valid", 64'(cmdout_out_tvalid), 64'd1);
    check_eq("fin1_data", cmdout_out_tdata, tid);
    tick();
    check_eq("fin_done_valid", 64'(cmdout_out_tvalid), 64'd0);
    check_eq("fin_idle_tready", 64'(cmdin_in_tready), 64'd1);
    cmdout_out_tready = 1'b0;
  endtask

  initial begin
    rstn              = 1'b0;
    cmdin_in_tvalid   = 1'b0;
    cmdin_in_tdata    = '0;
    cmdin_in_tlast    = 1'b0;
    cmdout_out_tready = 1'b0;
    task_start_ready  = 1'b0;
    task_done_valid   = 1'b0;
    arg_idx           = '0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Reset state
    check_eq("rst_out_valid", 64'(cmdout_out_tvalid), 64'd0);
    check_eq("rst_start", 64'(task_start_valid), 64'd0);
    check_eq("rst_done_ready", 64'(task_done_ready), 64'd0);
    check_eq("rst_nargs", 64'(task_nargs), 64'd0);
    check_eq("rst_task_id", task_id, 64'd0);
    check_eq("rst_err", 64'(err_sticky), 64'd0);
    check_eq("rst_tid", 64'(cmdout_out_tid), 64'(ACC_ID));
    check_eq("rst_out_data", cmdout_out_tdata, 64'd0);

    // Basic exec, 2 arguments
    send(64'h0000_0000_0000_0201, 1'b0);
    send(64'hA5, 1'b0);
    send(64'h7, 1'b0);
    send(64'h11, 1'b0);
    send(64'h22, 1'b1);
    check_eq("t1_start", 64'(task_start_valid), 64'd1);
    check_eq("t1_nargs", 64'(task_nargs), 64'd2);
    check_eq("t1_task_id", task_id, 64'hA5);
    check_eq("t1_parent_id", parent_id, 64'h7);
    check_eq("t1_tready", 64'(cmdin_in_tready), 64'd0);
    check_arg("t1_arg0", 8'd0, 64'h11);
    check_arg("t1_arg1", 8'd1, 64'h22);
    check_arg("t1_arg2_oob", 8'd2, 64'h0);
    finish(64'hA5);

    // nargs = 0, three beats
    send(64'h0000_0000_0000_0001, 1'b0);
    send(64'hB1, 1'b0);
    send(64'hB2, 1'b1);
    check_eq("t2_start", 64'(task_start_valid), 64'd1);
    check_eq("t2_nargs", 64'(task_nargs), 64'd0);
    check_eq("t2_parent_id", parent_id, 64'hB2);
    check_arg("t2_arg0", 8'd0, 64'h0);
    finish(64'hB1);

    // Argument overflow: 20 arguments into a 15-deep buffer
    send(64'h0000_0000_0000_1401, 1'b0);
    send(64'hC0, 1'b0);
    send(64'hC1, 1'b0);
    for (int i = 0; i < 20; i++) send(64'h100 + 64'(i), (i == 19));
    check_eq("t3_start", 64'(task_start_valid), 64'd1);
    check_eq("t3_nargs", 64'(task_nargs), 64'd15);
    check_eq("t3_err", 64'(err_sticky), 64'h2);
    check_arg("t3_arg0", 8'd0, 64'h100);
    check_arg("t3_arg14", 8'd14, 64'h10E);
    check_arg("t3_arg15_oob", 8'd15, 64'h0);
    finish(64'hC0);

    // Unknown code is drained, then a valid command runs
    send(64'h0000_0000_0000_0205, 1'b0);
    send(64'hDEAD, 1'b0);
    send(64'hBEEF, 1'b0);
    send(64'hCAFE, 1'b1);
    check_eq("t4_no_start", 64'(task_start_valid), 64'd0);
    check_eq("t4_idle_tready", 64'(cmdin_in_tready), 64'd1);
    check_eq("t4_err", 64'(err_sticky), 64'h3);
    send(64'h0000_0000_0000_0101, 1'b0);
    send(64'hD0, 1'b0);
    send(64'hD1, 1'b0);
    send(64'h33, 1'b1);
    check_eq("t4_start", 64'(task_start_valid), 64'd1);
    check_eq("t4_nargs", 64'(task_nargs), 64'd1);
    check_arg("t4_arg0", 8'd0, 64'h33);

    // Commands offered while busy are stalled; finish beat held under backpressure
    cmdin_in_tvalid = 1'b1;
    cmdin_in_tdata  = 64'h0000_0000_0000_0001;
    tick();
    check_eq("t5_start_stall", 64'(cmdin_in_tready), 64'd0);
    task_start_ready = 1'b1;
    tick();
    task_start_ready = 1'b0;
    check_eq("t5_run_stall", 64'(cmdin_in_tready), 64'd0);
    task_done_valid = 1'b1;
    tick();
    task_done_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_hold_valid", 64'(cmdout_out_tvalid), 64'd1);
      check_eq("t5_hold_data", cmdout_out_tdata, 64'h3);
      check_eq("t5_fin_stall", 64'(cmdin_in_tready), 64'd0);
      tick();
    end
    cmdin_in_tvalid   = 1'b0;
    cmdout_out_tready = 1'b1;
    tick();
    check_eq("t5_fin1_data", cmdout_out_tdata, 64'hD0);
    tick();
    check_eq("t5_done_valid", 64'(cmdout_out_tvalid), 64'd0);
    cmdout_out_tready = 1'b0;

    // Reset during ARGS abandons the command
    send(64'h0000_0000_0000_0301, 1'b0);
    send(64'hE0, 1'b0);
    send(64'hE1, 1'b0);
    send(64'h44, 1'b0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check_eq("t6_rst_valid", 64'(cmdout_out_tvalid), 64'd0);
    check_eq("t6_rst_start", 64'(task_start_valid), 64'd0);
    check_eq("t6_rst_err", 64'(err_sticky), 64'd0);
    check_eq("t6_rst_task_id", task_id, 64'd0);
    check_eq("t6_rst_tready", 64'(cmdin_in_tready), 64'd1);
    send(64'h0000_0000_0000_0101, 1'b0);
    send(64'hF0, 1'b0);
    send(64'hF1, 1'b0);
    send(64'h55, 1'b1);
    check_eq("t6_start", 64'(task_start_valid), 64'd1);
    check_eq("t6_no_fin", 64'(cmdout_out_tvalid), 64'd0);
    check_eq("t6_nargs", 64'(task_nargs), 64'd1);
    check_arg("t6_arg0", 8'd0, 64'h55);
    finish(64'hF0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
